// File: rtl/z80fi_trace_capture.sv
// ============================================================================
// z80fi_trace_capture : z80fi packet producer (one packet per retired insn)
// Rev 1.0
// ============================================================================
`default_nettype none

module z80fi_trace_capture #(
    parameter int MAX_INSN_BYTES = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 insn_start,
    input  logic                                 fetch_valid,
    input  logic [7:0]                           fetch_byte,
    input  logic                                 insn_done,
    input  logic [15:0]                          reg_ip,
    input  logic [7:0]                           reg_a,
    input  logic [7:0]                           reg_f,
    input  logic [7:0]                           reg_r,
    input  logic                                 reg_iff2,
    output logic                                 z80fi_valid,
    output logic [8*MAX_INSN_BYTES-1:0]          z80fi_insn,
    output logic [$clog2(MAX_INSN_BYTES+1)-1:0]  z80fi_insn_len,
    output logic [15:0]                          z80fi_reg_ip_in,
    output logic [7:0]                           z80fi_reg_a_in,
    output logic [7:0]                           z80fi_reg_f_in,
    output logic [7:0]                           z80fi_reg_r_in,
    output logic                                 z80fi_reg_iff2_in,
    output logic [15:0]                          z80fi_reg_ip_out,
    output logic [7:0]                           z80fi_reg_a_out,
    output logic [7:0]                           z80fi_reg_f_out,
    output logic [7:0]                           z80fi_reg_r_out,
    output logic                                 z80fi_reg_iff2_out,
    output logic                                 z80fi_overflow
);

    localparam int LW = $clog2(MAX_INSN_BYTES + 1);
    localparam int BW = 8 * MAX_INSN_BYTES;
    localparam int SW = 41;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [SW-1:0]   snap_in_q, snap_in_d;

    logic            valid_q, valid_d;
    logic [BW-1:0]   pkt_insn_q, pkt_insn_d;
    logic [LW-1:0]   pkt_len_q, pkt_len_d;
    logic [SW-1:0]   pkt_in_q, pkt_in_d;
    logic [SW-1:0]   pkt_out_q, pkt_out_d;
    logic            pkt_ovf_q, pkt_ovf_d;

    logic [SW-1:0]   regs_now;
    logic [BW-1:0]   fb_buf, st_buf;
    logic [LW-1:0]   fb_cnt, st_cnt;
    logic            fb_ovf;

    assign regs_now = {reg_ip, reg_a, reg_f, reg_r, reg_iff2};

    // Current buffer with this cycle's fetch applied (saturating at MAX).
    always_comb begin
        fb_buf = buf_q;
        fb_cnt = cnt_q;
        fb_ovf = ovf_q;
        if (fetch_valid) begin
            if (cnt_q < LW'(MAX_INSN_BYTES)) begin
                for (int k = 0; k < MAX_INSN_BYTES; k++) begin
                    if (cnt_q == LW'(k)) begin
                        fb_buf[8*k +: 8] = fetch_byte;
                    end
                end
                fb_cnt = cnt_q + LW'(1);
            end else begin
                fb_ovf = 1'b1;
            end
        end
    end

    // Fresh buffer for a newly started instruction, holding byte 0 if fetched.
    always_comb begin
        st_buf      = '0;
        st_buf[7:0] = fetch_valid ? fetch_byte : 8'h00;
        st_cnt      = fetch_valid ? LW'(1) : LW'(0);
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        snap_in_d  = snap_in_q;
        valid_d    = 1'b0;
        pkt_insn_d = pkt_insn_q;
        pkt_len_d  = pkt_len_q;
        pkt_in_d   = pkt_in_q;
        pkt_out_d  = pkt_out_q;
        pkt_ovf_d  = pkt_ovf_q;

        case (state_q)
            IDLE: begin
                if (insn_start) begin
                    state_d   = CAPTURE;
                    buf_d     = st_buf;
                    cnt_d     = st_cnt;
                    ovf_d     = 1'b0;
                    snap_in_d = regs_now;
                end
            end
            CAPTURE: begin
                if (insn_done) begin
                    valid_d    = 1'b1;
                    pkt_insn_d = fb_buf;
                    pkt_len_d  = fb_cnt;
                    pkt_ovf_d  = fb_ovf;
                    pkt_in_d   = snap_in_q;
                    pkt_out_d  = regs_now;
                    // A same-cycle fetch belongs to the retiring insn, so the
                    // follow-on capture starts empty.
                    if (insn_start) begin
                        buf_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        snap_in_d = regs_now;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (insn_start) begin
                    buf_d     = st_buf;
                    cnt_d     = st_cnt;
                    ovf_d     = 1'b0;
                    snap_in_d = regs_now;
                end else begin
                    buf_d = fb_buf;
                    cnt_d = fb_cnt;
                    ovf_d = fb_ovf;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            snap_in_q  <= '0;
            valid_q    <= 1'b0;
            pkt_insn_q <= '0;
            pkt_len_q  <= '0;
            pkt_in_q   <= '0;
            pkt_out_q  <= '0;
            pkt_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            snap_in_q  <= snap_in_d;
            valid_q    <= valid_d;
            pkt_insn_q <= pkt_insn_d;
            pkt_len_q  <= pkt_len_d;
            pkt_in_q   <= pkt_in_d;
            pkt_out_q  <= pkt_out_d;
            pkt_ovf_q  <= pkt_ovf_d;
        end
    end

    assign z80fi_valid    = valid_q;
    assign z80fi_insn     = pkt_insn_q;
    assign z80fi_insn_len = pkt_len_q;
    assign z80fi_overflow = pkt_ovf_q;

    assign {z80fi_reg_ip_in, z80fi_reg_a_in, z80fi_reg_f_in,
            z80fi_reg_r_in, z80fi_reg_iff2_in}   = pkt_in_q;
    assign {z80fi_reg_ip_out, z80fi_reg_a_out, z80fi_reg_f_out,
            z80fi_reg_r_out, z80fi_reg_iff2_out} = pkt_out_q;

endmodule

`default_nettype wire
